// File: rtl/speaker_tone_player.sv
// Note-command speaker peripheral: queues MCU note writes in a small FIFO
// and plays each one as a square wave, pulsing irq when the queue drains.
module speaker_tone_player #(
    parameter logic [7:0] SPEAKER_ID  = 8'h82,
    parameter logic [7:0] STATUS_ID   = 8'h83,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         HALF_BASE   = 1_500,
    parameter int         UNIT_CYCLES = 12_500_000,
    parameter int         IRQ_WIDTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] rd_data,
    output logic       irq,
    output logic       speaker
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(4 * UNIT_CYCLES);
    localparam int IW = $clog2(IRQ_WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PLAY = 2'd2;

    logic          strb_q;
    logic          wr;
    logic          flush;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          note_end;
    logic          is_rest;
    logic          overflow;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [7:0]    note;
    logic [1:0]    state;
    logic [DW-1:0] dur_cnt;
    logic [DW-1:0] dur_load;
    logic [23:0]   half_cnt;
    logic [23:0]   half_load;
    logic [IW-1:0] irq_cnt;

    // Strobe is a multi-cycle level from the slower MCU domain; act on its rising edge only.
    assign wr       = io_strb & ~strb_q & (port_id == SPEAKER_ID);
    assign flush    = wr & (out_port == 8'h00);
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign note_end = (state == PLAY) && (dur_cnt == '0);
    assign pop      = ~empty & ((state == IDLE) | note_end);
    assign push     = wr & ~flush & (~full | pop);
    assign is_rest  = (note[5:0] == 6'd0);
    assign irq      = (irq_cnt != '0);

    assign dur_load  = DW'((int'(note[7:6]) + 1) * UNIT_CYCLES - 1);
    assign half_load = 24'(HALF_BASE * (64 - int'(note[5:0])) - 1);

    assign rd_data = (port_id == STATUS_ID)
                   ? {state != IDLE, full, empty, overflow, 1'b0, 3'(count)}
                   : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) strb_q <= 1'b0;
        else          strb_q <= io_strb;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= out_port;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (wr & full & ~pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            note     <= 8'h00;
            dur_cnt  <= '0;
            half_cnt <= '0;
            speaker  <= 1'b0;
            irq_cnt  <= '0;
        end else if (flush) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            half_cnt <= '0;
            speaker  <= 1'b0;
            irq_cnt  <= '0;
        end else begin
            if (irq_cnt != '0) irq_cnt <= irq_cnt - IW'(1);
            if (pop) note <= mem[rptr];
            case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    if (pop) state <= LOAD;
                end
                LOAD: begin
                    dur_cnt  <= dur_load;
                    half_cnt <= half_load;
                    speaker  <= 1'b0;
                    state    <= PLAY;
                end
                PLAY: begin
                    if (note_end) begin
                        speaker <= 1'b0;
                        if (pop) begin
                            state <= LOAD;
                        end else begin
                            state   <= IDLE;
                            irq_cnt <= IW'(IRQ_WIDTH);
                        end
                    end else begin
                        dur_cnt <= dur_cnt - DW'(1);
                        if (half_cnt == '0) begin
                            half_cnt <= half_load;
                            if (!is_rest) speaker <= ~speaker;
                        end else begin
                            half_cnt <= half_cnt - 24'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_speaker_tone_player.sv
// Scoreboard bench for speaker_tone_player: a note-level reference model
// predicts speaker, irq and status every cycle; a monitor compares.
module tb_speaker_tone_player;

    localparam logic [7:0] SPK   = 8'h82;
    localparam logic [7:0] STS   = 8'h83;
    localparam int         DEPTH = 4;
    localparam int         HB    = 1;
    localparam int         UNIT  = 20;
    localparam int         IRQW  = 4;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_PLAY = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] port_id = STS;
    logic [7:0] out_port = 8'h00;
    logic       io_strb = 1'b0;
    logic [7:0] rd_data;
    logic       irq;
    logic       speaker;

    speaker_tone_player #(
        .SPEAKER_ID (SPK),
        .STATUS_ID  (STS),
        .FIFO_DEPTH (DEPTH),
        .HALF_BASE  (HB),
        .UNIT_CYCLES(UNIT),
        .IRQ_WIDTH  (IRQW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .port_id (port_id),
        .out_port(out_port),
        .io_strb (io_strb),
        .rd_data (rd_data),
        .irq     (irq),
        .speaker (speaker)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       spk;
        logic       irq;
        logic [7:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] mq[$];
    logic [7:0] cur = 8'h00;
    int         phase = M_IDLE;
    int         k = 0;
    int         irq_left = 0;
    bit         ovf = 1'b0;
    bit         sq = 1'b0;

    function automatic int dur_of(input logic [7:0] c);
        return (int'(c[7:6]) + 1) * UNIT;
    endfunction

    function automatic int half_of(input logic [7:0] c);
        return HB * (64 - int'(c[5:0]));
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] pid, input logic [7:0] d,
                              input logic s, input logic rst, output exp_t e);
        bit wr;
        bit popped;
        bit was_full;
        bit was_empty;
        if (rst) begin
            mq.delete();
            phase = M_IDLE;
            k = 0;
            irq_left = 0;
            ovf = 1'b0;
            sq = 1'b0;
        end else begin
            wr = s && !sq && (pid == SPK);
            sq = s;
            if (wr && d == 8'h00) begin
                mq.delete();
                phase = M_IDLE;
                k = 0;
                irq_left = 0;
                ovf = 1'b0;
            end else begin
                popped = 1'b0;
                was_full = (mq.size() == DEPTH);
                was_empty = (mq.size() == 0);
                irq_left = (irq_left > 0) ? irq_left - 1 : 0;
                if (phase == M_IDLE) begin
                    if (!was_empty) begin
                        cur = mq.pop_front();
                        popped = 1'b1;
                        phase = M_LOAD;
                    end
                end else if (phase == M_LOAD) begin
                    phase = M_PLAY;
                    k = 1;
                end else if (k == dur_of(cur)) begin
                    if (!was_empty) begin
                        cur = mq.pop_front();
                        popped = 1'b1;
                        phase = M_LOAD;
                    end else begin
                        phase = M_IDLE;
                        irq_left = IRQW;
                    end
                end else begin
                    k++;
                end
                if (wr) begin
                    if (!was_full || popped) mq.push_back(d);
                    else ovf = 1'b1;
                end
            end
        end
        e.spk = (phase == M_PLAY && cur[5:0] != 6'd0)
              ? (((k - 1) / half_of(cur)) % 2 == 1) : 1'b0;
        e.irq = (irq_left > 0);
        e.rd  = (pid == STS)
              ? {phase != M_IDLE, mq.size() == DEPTH, mq.size() == 0,
                 ovf, 1'b0, 3'(mq.size())}
              : 8'h00;
    endtask

    task automatic cyc(input logic [7:0] pid, input logic [7:0] d,
                       input logic s, input logic rst);
        exp_t e;
        @(negedge clk);
        port_id  = pid;
        out_port = d;
        io_strb  = s;
        reset_n  = ~rst;
        model_step(pid, d, s, rst, e);
        exp_q.push_back(e);
        if (rst) begin
            #1;
            check("async_reset_speaker", speaker, 0);
            check("async_reset_irq", irq, 0);
        end
    endtask

    task automatic wr_note(input logic [7:0] b);
        cyc(SPK, b, 1'b1, 1'b0);
        cyc(SPK, b, 1'b1, 1'b0);
        cyc(STS, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(STS, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic idle_rand(input int n);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = ($urandom_range(0, 2) == 0) ? 8'($urandom) : STS;
            cyc(p, 8'($urandom), 1'b0, 1'b0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("speaker", speaker, e.spk);
                check("irq", irq, e.irq);
                check("rd_data", rd_data, e.rd);
            end
        end
    end

    initial begin : stim
        int r;
        logic [7:0] c;
        for (int i = 0; i < 3; i++) cyc(STS, 8'h00, 1'b0, 1'b1);
        idle(3);

        wr_note(8'h3F);
        idle(40);

        wr_note(8'h41);
        idle(60);

        wr_note(8'h3E);
        wr_note(8'h30);
        wr_note(8'h3A);
        wr_note(8'h05);
        wr_note(8'h81);
        wr_note(8'h3C);
        idle(200);

        wr_note(8'h7C);
        idle(10);
        wr_note(8'h00);
        idle(10);

        wr_note(8'hBD);
        wr_note(8'h20);
        idle(12);
        cyc(STS, 8'h00, 1'b0, 1'b1);
        cyc(STS, 8'h00, 1'b0, 1'b1);
        idle(10);

        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                c = 8'($urandom);
                if ($urandom_range(0, 19) == 0) c = 8'h00;
                wr_note(c);
            end else if (r < 52) begin
                c = 8'($urandom);
                cyc(c, 8'($urandom), 1'b1, 1'b0);
                cyc(c, 8'($urandom), 1'b1, 1'b0);
                cyc(STS, 8'h00, 1'b0, 1'b0);
            end else if (r < 97) begin
                idle_rand($urandom_range(1, 25));
            end else begin
                cyc(STS, 8'h00, 1'b0, 1'b1);
                cyc(STS, 8'h00, 1'b0, 1'b1);
            end
        end

        idle(500);
        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
